// File: rtl/controller_sseg_wr_strobe.sv
// Avalon-MM output port for the seven-segment write path: DATA/SET/CLEAR output register
// with a timed write strobe (setup delay, then programmable-length pulse) and busy/overrun status.
module controller_sseg_wr_strobe #(
  parameter int          WIDTH         = 4,
  parameter int          SETUP_CYCLES  = 2,
  parameter int          PW_BITS       = 8,
  parameter int          DEFAULT_PULSE = 4,
  parameter logic [31:0] RESET_VALUE   = 32'd0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             strobe,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE} state_t;

  localparam logic [7:0]         SETUP_LOAD = 8'(SETUP_CYCLES);
  localparam logic [PW_BITS-1:0] PULSE_RST  = PW_BITS'(DEFAULT_PULSE);
  localparam logic [PW_BITS-1:0] PULSE_ONE  = PW_BITS'(1);

  state_t             state, state_next;
  logic [7:0]         setup_cnt, setup_cnt_next;
  logic [PW_BITS-1:0] pulse_cnt, pulse_cnt_next;
  logic [PW_BITS-1:0] pulse_len;
  logic               overrun;
  logic [WIDTH-1:0]   out_next;
  logic [PW_BITS-1:0] pulse_load;
  logic               wr_en, data_wr, accept, drop, unused_bits;

  assign wr_en       = chipselect && !write_n;
  assign data_wr     = wr_en && (address <= 3'd2);
  assign accept      = data_wr && !busy;
  assign drop        = data_wr && busy;
  assign pulse_load  = (pulse_len == '0) ? PULSE_ONE : pulse_len;
  assign unused_bits = ^writedata;

  always_comb begin
    out_next = out_port;
    case (address)
      3'd0:    out_next = writedata[WIDTH-1:0];
      3'd1:    out_next = out_port | writedata[WIDTH-1:0];
      3'd2:    out_next = out_port & ~writedata[WIDTH-1:0];
      default: out_next = out_port;
    endcase
  end

  // The pulse counter is loaded at the accepting edge, which latches the pulse length.
  always_comb begin
    state_next     = state;
    setup_cnt_next = setup_cnt;
    pulse_cnt_next = pulse_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          pulse_cnt_next = pulse_load;
          if (SETUP_CYCLES == 0) begin
            state_next = PULSE;
          end else begin
            state_next     = SETUP;
            setup_cnt_next = SETUP_LOAD;
          end
        end
      end
      SETUP: begin
        if (setup_cnt <= 8'd1) state_next = PULSE;
        else                   setup_cnt_next = setup_cnt - 8'd1;
      end
      PULSE: begin
        if (pulse_cnt <= PULSE_ONE) state_next = IDLE;
        else                        pulse_cnt_next = pulse_cnt - PULSE_ONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      setup_cnt <= 8'd0;
      pulse_cnt <= '0;
      strobe    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      setup_cnt <= setup_cnt_next;
      pulse_cnt <= pulse_cnt_next;
      strobe    <= (state_next == PULSE);
      busy      <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port  <= RESET_VALUE[WIDTH-1:0];
      pulse_len <= PULSE_RST;
      overrun   <= 1'b0;
    end else begin
      if (accept) out_port <= out_next;
      if (wr_en && address == 3'd3) pulse_len <= writedata[PW_BITS-1:0];
      if (drop)                                          overrun <= 1'b1;
      else if (wr_en && address == 3'd4 && writedata[1]) overrun <= 1'b0;
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      3'd0:    readdata[WIDTH-1:0]   = out_port;
      3'd3:    readdata[PW_BITS-1:0] = pulse_len;
      3'd4:    readdata[1:0]         = {overrun, busy};
      default: readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_controller_sseg_wr_strobe.sv
// Bench for controller_sseg_wr_strobe: two instances (SETUP_CYCLES 2 and 0) on one bus,
// a timeline model checked every cycle, plus literal expectations from hand-worked timing.
module tb_controller_sseg_wr_strobe;
  logic        clk = 0, reset_n = 0;
  logic [2:0]  address = 0;
  logic        chipselect = 0, write_n = 1;
  logic [31:0] writedata = 0;
  logic [31:0] rd [2];
  logic [3:0]  op [2];
  logic        st [2], bz [2];

  int checks = 0, passes = 0;

  always #5 clk = ~clk;

  controller_sseg_wr_strobe u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[0]), .out_port(op[0]),
    .strobe(st[0]), .busy(bz[0]));

  controller_sseg_wr_strobe #(.SETUP_CYCLES(0)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[1]), .out_port(op[1]),
    .strobe(st[1]), .busy(bz[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: each accepted data write at edge n is recorded as a timeline window
  // [start, fall) for busy and [rise, fall) for strobe.
  int         cyc = 0;
  int         m_start [2] = '{0, 0};
  int         m_rise  [2] = '{0, 0};
  int         m_fall  [2] = '{0, 0};
  logic [3:0] m_out   [2] = '{4'd0, 4'd0};
  logic       m_ovr   [2] = '{1'b0, 1'b0};
  logic [7:0] m_plen = 8'd4;

  function automatic int setup_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic logic m_busy(input int i, input int c);
    return (c >= m_start[i]) && (c < m_fall[i]);
  endfunction

  function automatic logic m_strobe(input int i, input int c);
    return (c >= m_rise[i]) && (c < m_fall[i]);
  endfunction

  function automatic logic [31:0] m_read(input int i, input logic [2:0] a);
    case (a)
      3'd0: return {28'd0, m_out[i]};
      3'd3: return {24'd0, m_plen};
      3'd4: return {30'd0, m_ovr[i], m_busy(i, cyc)};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_out[i] = 4'd0; m_ovr[i] = 1'b0;
        m_start[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
      end
      m_plen = 8'd4;
    end else begin
      cyc++;
      if (chipselect && !write_n) begin
        for (int i = 0; i < 2; i++) begin
          if (address <= 3'd2) begin
            if (m_busy(i, cyc - 1)) m_ovr[i] = 1'b1;
            else begin
              case (address)
                3'd0: m_out[i] = writedata[3:0];
                3'd1: m_out[i] = m_out[i] | writedata[3:0];
                default: m_out[i] = m_out[i] & ~writedata[3:0];
              endcase
              m_start[i] = cyc;
              m_rise[i]  = cyc + setup_of(i);
              m_fall[i]  = m_rise[i] + ((m_plen == 0) ? 1 : int'(m_plen));
            end
          end else if (address == 3'd4 && writedata[1]) m_ovr[i] = 1'b0;
        end
        if (address == 3'd3) m_plen = writedata[7:0];
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model out_port[%0d]", i), {28'd0, op[i]}, {28'd0, m_out[i]});
      chk($sformatf("model strobe[%0d]", i), {31'd0, st[i]}, {31'd0, m_strobe(i, cyc)});
      chk($sformatf("model busy[%0d]", i), {31'd0, bz[i]}, {31'd0, m_busy(i, cyc)});
      chk($sformatf("model readdata[%0d] a%0d", i, address), rd[i], m_read(i, address));
    end
  end

  // Callers sit 1 time unit after a rising edge; returns 1 unit after the accepting edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    @(posedge clk); #1;
    chipselect = 0; write_n = 1; writedata = 0;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a; #1;
    chk(name, rd[0], exp);
  endtask

  task automatic wait_idle();
    for (int g = 0; g < 200 && bz[0]; g++) begin
      @(posedge clk); #1;
    end
    chk("idle within bound", {31'd0, bz[0]}, 32'd0);
  endtask

  task automatic measure(output int n);
    n = 0;
    for (int g = 0; g < 200 && bz[0]; g++) begin
      if (st[0]) n++;
      @(posedge clk); #1;
    end
  endtask

  localparam logic [7:0] STROBE_PAT = 8'b0011_1100;  // bit k = strobe after edge N+k
  localparam logic [7:0] BUSY_PAT   = 8'b0011_1111;

  initial begin
    int n, gap;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_port", {28'd0, op[0]}, 32'd0);
    chk("reset strobe", {31'd0, st[0]}, 32'd0);
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;
    rd_chk("reset PULSE_LEN", 3'd3, 32'd4);
    rd_chk("reset STATUS", 3'd4, 32'd0);

    // default sequence
    @(posedge clk); #1;
    wr(3'd0, 32'hA);
    chk("data out_port", {28'd0, op[0]}, 32'hA);
    chk("setup0 strobe at N", {31'd0, st[1]}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("strobe N+%0d", k), {31'd0, st[0]}, {31'd0, STROBE_PAT[k]});
      chk($sformatf("busy N+%0d", k), {31'd0, bz[0]}, {31'd0, BUSY_PAT[k]});
      @(posedge clk); #1;
    end
    rd_chk("DATA read", 3'd0, 32'hA);

    // SET / CLEAR
    @(posedge clk); #1;
    wr(3'd0, 32'h5); wait_idle();
    wr(3'd1, 32'h2);
    chk("SET out_port", {28'd0, op[0]}, 32'h7);
    measure(n); chk("SET pulse len", n, 4);
    wr(3'd2, 32'h4);
    chk("CLEAR out_port", {28'd0, op[0]}, 32'h3);
    measure(n); chk("CLEAR pulse len", n, 4);
    rd_chk("SET reads 0", 3'd1, 32'd0);
    rd_chk("CLEAR reads 0", 3'd2, 32'd0);

    // overrun
    @(posedge clk); #1;
    wr(3'd0, 32'h1); wr(3'd0, 32'hF);
    chk("overrun out_port", {28'd0, op[0]}, 32'h1);
    rd_chk("STATUS busy+ovr", 3'd4, 32'h3);
    wait_idle();
    rd_chk("STATUS ovr sticky", 3'd4, 32'h2);
    @(posedge clk); #1;
    wr(3'd4, 32'h2);
    rd_chk("STATUS cleared", 3'd4, 32'h0);

    // pulse length
    @(posedge clk); #1;
    wr(3'd3, 32'h0); wr(3'd0, 32'h6);
    measure(n); chk("PULSE_LEN 0 as 1", n, 1);
    wr(3'd3, 32'h2); wr(3'd0, 32'h7); wr(3'd3, 32'h9);
    measure(n); chk("pulse keeps old len", n, 2);
    wr(3'd0, 32'h8);
    measure(n); chk("next pulse len 9", n, 9);

    // back-to-back
    wr(3'd0, 32'h1); wait_idle();
    gap = 1;
    wr(3'd0, 32'h2);
    chk("b2b accepted", {28'd0, op[0]}, 32'h2);
    for (int g = 0; g < 50 && !st[0]; g++) begin
      gap++;
      @(posedge clk); #1;
    end
    chk("b2b strobe gap", gap, 3);
    rd_chk("b2b no overrun", 3'd4, 32'h1);
    wait_idle();

    // reset mid-PULSE
    wr(3'd0, 32'h3);
    repeat (2) begin @(posedge clk); #1; end
    chk("in PULSE before reset", {31'd0, st[0]}, 32'd1);
    #2 reset_n = 0;
    #1;
    chk("async strobe drop", {31'd0, st[0]}, 32'd0);
    chk("reset out_port mid", {28'd0, op[0]}, 32'd0);
    chk("reset busy mid", {31'd0, bz[0]}, 32'd0);
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;
    rd_chk("PULSE_LEN after reset", 3'd3, 32'd4);
    rd_chk("STATUS after reset", 3'd4, 32'd0);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
